// File: rtl/z80_bus_pkg.sv
// Shared types and helpers for the Z80 bus-timing / interrupt controller.
//   wait_state_e  : wait-state FSM encoding
//   Def*          : default timing constants
//   region_match  : priority address-region match (lowest index wins)
package z80_bus_pkg;

  localparam int unsigned DefClkDiv   = 4;
  localparam int unsigned DefNmiWidth = 4;
  localparam int unsigned DefIntHold  = 2048;

  // Upper bound on regions; the decoder pads its inputs to this size.
  localparam int MaxRegions = 8;

  typedef enum logic [1:0] {
    StIdle,
    StCount,
    StReady,
    StHold
  } wait_state_e;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } region_hit_t;

  // Scan from the top so the lowest matching index is the one left standing.
  function automatic region_hit_t region_match(
    input logic [15:0]              addr,
    input logic [16*MaxRegions-1:0] base,
    input logic [16*MaxRegions-1:0] mask,
    input int                       n
  );
    region_hit_t res;
    res = '0;
    for (int i = MaxRegions - 1; i >= 0; i--) begin
      if (i < n && (((addr ^ base[16*i +: 16]) & mask[16*i +: 16]) == 16'h0000)) begin
        res.hit = 1'b1;
        res.idx = 3'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/z80_region_decode.sv
// Combinational priority match of the CPU address against N_REGIONS
// base/mask pairs, returning the winning region's wait count and ready flag.
//   addr_i  : CPU address
//   base_i  : region bases, region i at [16i+15:16i]
//   mask_i  : region compare masks (1 = compare bit)
//   wait_i  : region wait counts, WAIT_BITS each
//   rdy_i   : region waits additionally for external ready
//   wait_o  : wait count of the winning region (0 on no match)
//   rdy_o   : ready flag of the winning region (0 on no match)
module z80_region_decode
  import z80_bus_pkg::*;
#(
  parameter int unsigned N_REGIONS = 2,
  parameter int unsigned WAIT_BITS = 3
) (
  input  logic [15:0]                    addr_i,
  input  logic [16*N_REGIONS-1:0]        base_i,
  input  logic [16*N_REGIONS-1:0]        mask_i,
  input  logic [WAIT_BITS*N_REGIONS-1:0] wait_i,
  input  logic [N_REGIONS-1:0]           rdy_i,
  output logic [WAIT_BITS-1:0]           wait_o,
  output logic                           rdy_o
);

  logic [16*MaxRegions-1:0] base_pad;
  logic [16*MaxRegions-1:0] mask_pad;
  region_hit_t              sel;

  always_comb begin
    base_pad = '0;
    mask_pad = '0;
    base_pad[16*N_REGIONS-1:0] = base_i;
    mask_pad[16*N_REGIONS-1:0] = mask_i;
    sel = region_match(addr_i, base_pad, mask_pad, int'(N_REGIONS));
    wait_o = '0;
    rdy_o  = 1'b0;
    for (int unsigned i = 0; i < N_REGIONS; i++) begin
      if (sel.hit && sel.idx == 3'(i)) begin
        wait_o = wait_i[i*WAIT_BITS +: WAIT_BITS];
        rdy_o  = rdy_i[i];
      end
    end
  end

endmodule

// File: rtl/z80_bus_ctrl.sv
// Bus-timing and interrupt controller for a Z80 sound/sub CPU.
// Generates the CPU clock enable, inserts per-region wait states (with an
// optional external ready handshake) and drives nINT/nNMI.
//   clk, reset      : system clock, async active-high reset
//   clken           : CPU clock enable, one clk wide every CLK_DIV clks
//   cpu_addr, nMREQ, nIORQ, nRD, nWR, nM1, nRFSH : CPU bus
//   region_base/mask/wait/rdy : wait-state region table
//   mem_ready       : slow-device ready level
//   irq_trig/irq_clr: interrupt request edge / software clear
//   nmi_trig        : NMI request edge
//   nWAIT, nINT, nNMI : to CPU; int_ack : one-clk acknowledge pulse
module z80_bus_ctrl
  import z80_bus_pkg::*;
#(
  parameter int unsigned CLK_DIV   = DefClkDiv,
  parameter int unsigned N_REGIONS = 2,
  parameter int unsigned WAIT_BITS = 3,
  parameter int unsigned IO_WAIT   = 0,
  parameter int unsigned INT_HOLD  = DefIntHold,
  parameter int unsigned NMI_WIDTH = DefNmiWidth
) (
  input  logic                           clk,
  input  logic                           reset,
  output logic                           clken,
  input  logic [15:0]                    cpu_addr,
  input  logic                           nMREQ,
  input  logic                           nIORQ,
  input  logic                           nRD,
  input  logic                           nWR,
  input  logic                           nM1,
  input  logic                           nRFSH,
  input  logic [16*N_REGIONS-1:0]        region_base,
  input  logic [16*N_REGIONS-1:0]        region_mask,
  input  logic [WAIT_BITS*N_REGIONS-1:0] region_wait,
  input  logic [N_REGIONS-1:0]           region_rdy,
  input  logic                           mem_ready,
  input  logic                           irq_trig,
  input  logic                           irq_clr,
  input  logic                           nmi_trig,
  output logic                           nWAIT,
  output logic                           nINT,
  output logic                           nNMI,
  output logic                           int_ack
);

  localparam int unsigned DivW = $clog2(CLK_DIV - 1) + 1;
  localparam int unsigned IntW = $clog2(INT_HOLD) + 1;
  localparam int unsigned NmiW = $clog2(NMI_WIDTH) + 1;

  localparam logic [DivW-1:0]      DivLast    = DivW'(CLK_DIV - 1);
  localparam logic [IntW-1:0]      IntLast    = IntW'((INT_HOLD == 0) ? 0 : INT_HOLD - 1);
  localparam logic [NmiW-1:0]      NmiLoad    = NmiW'(NMI_WIDTH);
  localparam logic [WAIT_BITS-1:0] IoWait     = WAIT_BITS'(IO_WAIT);
  localparam bit                   IntTimeout = (INT_HOLD != 0);

  // Clock enable divider, free-running.
  logic [DivW-1:0] div_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
    end else if (div_q == DivLast) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DivW'(1);
    end
  end

  assign clken = (div_q == DivLast);

  // Access detection.
  logic mem_acc, io_acc, acc, acc_q, acc_start;

  assign mem_acc   = ~nMREQ & nRFSH & (~nRD | ~nWR);
  assign io_acc    = ~nIORQ & nM1;
  assign acc       = mem_acc | io_acc;
  assign acc_start = acc & ~acc_q;

  logic [WAIT_BITS-1:0] reg_wait;
  logic                 reg_rdy;

  z80_region_decode #(
    .N_REGIONS(N_REGIONS),
    .WAIT_BITS(WAIT_BITS)
  ) u_region_decode (
    .addr_i(cpu_addr),
    .base_i(region_base),
    .mask_i(region_mask),
    .wait_i(region_wait),
    .rdy_i (region_rdy),
    .wait_o(reg_wait),
    .rdy_o (reg_rdy)
  );

  logic [WAIT_BITS-1:0] acc_wait;
  logic                 acc_rdy;

  // Region table applies to memory cycles only; I/O gets a fixed count.
  assign acc_wait = mem_acc ? reg_wait : IoWait;
  assign acc_rdy  = mem_acc & reg_rdy;

  // Wait-state FSM.
  wait_state_e          state_q, state_d;
  logic [WAIT_BITS-1:0] wcnt_q, wcnt_d;
  logic                 rdy_q, rdy_d;
  logic                 nwait_q, nwait_d;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    rdy_d   = rdy_q;
    unique case (state_q)
      StIdle: begin
        if (acc_start) begin
          wcnt_d = acc_wait;
          rdy_d  = acc_rdy;
          if (acc_wait != '0) begin
            state_d = StCount;
          end else if (acc_rdy) begin
            state_d = StReady;
          end else begin
            state_d = StHold;
          end
        end
      end
      StCount: begin
        if (!acc) begin
          state_d = StIdle;
        end else if (clken) begin
          wcnt_d = wcnt_q - WAIT_BITS'(1);
          if (wcnt_q == WAIT_BITS'(1)) begin
            state_d = rdy_q ? StReady : StHold;
          end
        end
      end
      StReady: begin
        if (!acc) begin
          state_d = StIdle;
        end else if (mem_ready) begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (!acc) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Registered so nWAIT follows the state being entered.
    nwait_d = ~((state_d == StCount) || (state_d == StReady));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      wcnt_q  <= '0;
      rdy_q   <= 1'b0;
      nwait_q <= 1'b1;
      acc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      rdy_q   <= rdy_d;
      nwait_q <= nwait_d;
      acc_q   <= acc;
    end
  end

  assign nWAIT = nwait_q;

  // Interrupt request latch.
  logic            irq_q, irq_edge_q, ack_q, int_ack_q;
  logic            pend_q, pend_d;
  logic [IntW-1:0] itick_q, itick_d;
  logic            ack, ack_rise, timeout;

  assign ack      = ~nM1 & ~nIORQ;
  assign ack_rise = ack & ~ack_q;
  assign timeout  = IntTimeout & pend_q & clken & (itick_q == IntLast);

  always_comb begin
    pend_d  = pend_q;
    itick_d = itick_q;
    if (pend_q && clken) begin
      itick_d = timeout ? '0 : itick_q + IntW'(1);
    end
    if (ack_rise || irq_clr || timeout) begin
      pend_d = 1'b0;
    end
    // A fresh request wins over any clear and restarts the timeout.
    if (irq_edge_q) begin
      pend_d  = 1'b1;
      itick_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q      <= 1'b0;
      irq_edge_q <= 1'b0;
      ack_q      <= 1'b0;
      int_ack_q  <= 1'b0;
      pend_q     <= 1'b0;
      itick_q    <= '0;
    end else begin
      irq_q      <= irq_trig;
      irq_edge_q <= irq_trig & ~irq_q;
      ack_q      <= ack;
      int_ack_q  <= ack_rise;
      pend_q     <= pend_d;
      itick_q    <= itick_d;
    end
  end

  assign nINT    = ~pend_q;
  assign int_ack = int_ack_q;

  // NMI pulse stretcher; a retrigger reloads without releasing nNMI.
  logic            nmi_q, nmi_rise;
  logic [NmiW-1:0] nmi_cnt_q, nmi_cnt_d;

  assign nmi_rise = nmi_trig & ~nmi_q;

  always_comb begin
    nmi_cnt_d = nmi_cnt_q;
    if (clken && nmi_cnt_q != '0) begin
      nmi_cnt_d = nmi_cnt_q - NmiW'(1);
    end
    if (nmi_rise) begin
      nmi_cnt_d = NmiLoad;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nmi_q     <= 1'b0;
      nmi_cnt_q <= '0;
    end else begin
      nmi_q     <= nmi_trig;
      nmi_cnt_q <= nmi_cnt_d;
    end
  end

  assign nNMI = (nmi_cnt_q == '0);

endmodule

// File: doc/z80_bus_ctrl.md
Name: z80_bus_ctrl

Overview:
Parametrised bus-timing and interrupt controller for a Z80 CPU instance (the cpu_z80 core), used for sound and sub CPUs.
- Generates the CPU clock enable.
- Inserts per-address-region wait states, with an optional external ready handshake.
- Latches interrupt and NMI requests and drives nINT/nNMI, with acknowledge, clear and timeout.
- Sits between the CPU wrapper and the board address decoder/memories.

Parameters:
CLK_DIV, 4, clk cycles per clken pulse (>=2)
N_REGIONS, 2, number of wait-state address regions (1..8)
WAIT_BITS, 3, width of per-region wait count
IO_WAIT, 0, extra wait clken ticks on I/O cycles (0..2^WAIT_BITS-1)
INT_HOLD, 2048, max clken ticks nINT stays low unacknowledged; 0 = no timeout
NMI_WIDTH, 4, nNMI low width in clken ticks (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
clken  out  1  CPU clock enable, one clk wide
cpu_addr  in  16  CPU address
nMREQ  in  1  CPU memory request (refresh already masked)
nIORQ  in  1  CPU I/O request
nRD  in  1  CPU read strobe
nWR  in  1  CPU write strobe
nM1  in  1  CPU M1
nRFSH  in  1  CPU refresh
region_base  in  16*N_REGIONS  region i base at [16i+15:16i]
region_mask  in  16*N_REGIONS  region i address compare mask (1 = compare)
region_wait  in  WAIT_BITS*N_REGIONS  region i wait ticks
region_rdy  in  N_REGIONS  region i additionally waits for mem_ready
mem_ready  in  1  external slow-device ready, level
irq_trig  in  1  interrupt request, rising-edge sensitive
irq_clr  in  1  software clear of pending interrupt, level
nmi_trig  in  1  NMI request, rising-edge sensitive
nWAIT  out  1  to CPU WAIT_n
nINT  out  1  to CPU INT_n
nNMI  out  1  to CPU NMI_n
int_ack  out  1  one-clk pulse on interrupt acknowledge

Behaviour:
- Reset (async): div counter=0, clken=0, wait FSM=IDLE, nWAIT=1, nINT=1, nNMI=1, int_ack=0, edge-detect registers=0. A reset mid-access returns everything to IDLE at once.
- clken: counter runs 0..CLK_DIV-1; clken=1 in the cycle count==CLK_DIV-1. It is free-running and never stopped by waits; waits act through nWAIT only.
- Access start is the rising edge of acc, where:
  - mem = !nMREQ & nRFSH & (!nRD | !nWR)
  - io = !nIORQ & nM1
  - acc = mem | io
- Region match (memory only): ((cpu_addr ^ base_i) & mask_i) == 0. The lowest matching index wins. No match means 0 waits, no ready. I/O uses IO_WAIT with no ready.
- Wait FSM, states IDLE, COUNT, READY, HOLD:
  - IDLE: on access start latch wait count w and rdy flag r.
    - w>0: go to COUNT, nWAIT=0 from the next clk.
    - w==0 and r: go to READY, nWAIT=0.
    - Otherwise: go to HOLD, nWAIT stays 1.
  - COUNT: decrement on each clken. On reaching 0, go to READY if r, else HOLD.
  - READY: leave for HOLD on the first clk with mem_ready=1.
  - HOLD: nWAIT=1; return to IDLE when acc=0.
  - If acc drops in COUNT or READY (abnormal), return to IDLE and set nWAIT=1.
- nWAIT is registered. One-clk latency after access start is sufficient because CLK_DIV>=2 and the CPU samples WAIT in T2.
- Interrupt:
  - A rising edge of irq_trig, via a 1-clk registered edge detector, sets pend; nINT = !pend.
  - Acknowledge is the rising edge of (!nM1 & !nIORQ). It clears pend and pulses int_ack once.
  - irq_clr=1 clears pend.
  - Timeout: a tick counter runs on clken while pend=1 and clears pend at INT_HOLD. The counter resets whenever pend is set.
  - A trigger edge in the same clk as acknowledge, clear or timeout leaves pend=1 (set wins) and restarts the timeout.
- NMI: a rising edge of nmi_trig loads a counter with NMI_WIDTH and drives nNMI=0. The counter decrements on clken; nNMI=1 when it reaches 0. A retrigger while low reloads the counter; there is no extra falling edge.
- Width rules: all counters are sized with $clog2 of their maximum value plus 1. Wait arithmetic is unsigned and does not wrap.

Decomposition:
- Package z80_bus_pkg holds:
  - the wait FSM state enum (IDLE/COUNT/READY/HOLD);
  - the default constants for CLK_DIV/NMI_WIDTH/INT_HOLD;
  - a region-decode function returning index and hit.
- One natural sub-module: z80_region_decode, combinational priority match over N_REGIONS producing w and r.
- Interrupt and NMI logic stay in the top module.

Test Plan:
- CLK_DIV=4, reset released: clken high at clk 3, 7, 11; all outputs 1 during reset and after it.
- Region0 base 0x8000 mask 0xC000 wait 3 rdy 0; memory read at 0x9234: nWAIT low 1 clk after start for exactly 3 clken ticks, then high. Read at 0x1000 (no match): nWAIT never low.
- Region1 wait 0 rdy 1, overlapping region0 with region0 wait 2: region0 wins (2 ticks, mem_ready ignored). With region0 masked off: nWAIT held low until mem_ready=1 and released the next clk.
- irq_trig pulse, then M1+IORQ acknowledge 10 clken later: nINT low from 2 clk after trigger, high after acknowledge, int_ack exactly 1 clk. With INT_HOLD=16 and no acknowledge: nINT high after 16 clken ticks.
- irq_trig edge coincident with irq_clr: nINT stays 0.
- nmi_trig edge, retriggered 2 ticks later, NMI_WIDTH=4: nNMI low continuously for 6 ticks. Reset asserted mid-COUNT: nWAIT=1 asynchronously and FSM back in IDLE.
